adc8_conv_sequencer: RTL
========================

# adc8_conv_sequencer

Conversion controller for the 8-bit rectifier ADCs that measure battery voltage and current. It periodically issues CONVST, waits for the ADC's end-of-conversion (EOC) falling edge, and captures the data bus. It outputs each sample with a one-cycle valid strobe, plus a block average, and flags conversions that never complete. It sits between the ADC_BAT_V/ADC_BAT_I pins and the sensing/PI-controller logic, with one instance per ADC.

## Interface
Parameters:
- CONV_PERIOD, 1000: clock cycles between successive CONVST rising edges (100 kHz at 100 MHz).
- CONVST_WIDTH, 10: cycles CONVST is held high.
- EOC_TIMEOUT, 500: max cycles spent in WAIT_EOC. Constraint: CONVST_WIDTH + EOC_TIMEOUT + 2 < CONV_PERIOD.
- AVG_LOG2, 2: log2 of the number of samples per average (1..4).

Ports (one clock; reset is asynchronous and active-low):
- i_CLK  in  1  system clock (clk_100M).
- i_RST  in  1  asynchronous active-low reset.
- i_enable  in  1  run conversions while high.
- i_clr_timeout  in  1  single-cycle pulse that clears o_timeout.
- i_EOC  in  1  ADC end-of-conversion; asynchronous; falling edge means data is valid.
- i_DATA  in  8  ADC data bus; stable while EOC is low.
- o_CONVST  out  1  conversion start to the ADC, active high.
- o_sample  out  8  last captured sample.
- o_sample_valid  out  1  one-cycle strobe, high when o_sample updates.
- o_avg  out  8  last block average.
- o_avg_valid  out  1  one-cycle strobe, high when o_avg updates.
- o_timeout  out  1  sticky flag for a missed EOC.

## Operation
- i_EOC passes through a 2-FF synchronizer (s1, s2) plus a previous-value register p. A falling edge is detected when p=1 and s2=0.
- States: IDLE, START, WAIT_EOC, CAPTURE, HOLD. A period counter runs 0..CONV_PERIOD-1.
- IDLE: CONVST=0. If i_enable=1, go to START and set the period counter to 0.
- START: CONVST=1 for CONVST_WIDTH cycles, then go to WAIT_EOC with the timeout counter at 0.
- WAIT_EOC: on a detected falling edge, go to CAPTURE. After EOC_TIMEOUT cycles without an edge, set o_timeout and go to HOLD without capturing.
- CAPTURE (one cycle):
  - Register i_DATA into o_sample and pulse o_sample_valid.
  - Add the sample into the accumulator (width 8+AVG_LOG2) and increment the sample count.
  - When the count reaches 2^AVG_LOG2: o_avg = (acc + sample) >> AVG_LOG2, truncated; pulse o_avg_valid in the same cycle; clear acc and count.
  - Then go to HOLD.
- HOLD: when the period counter equals CONV_PERIOD-1, go to START and set the counter to 0.
- A falling edge of EOC in any state other than WAIT_EOC is ignored.
- If i_enable goes low in any state, the next edge moves to IDLE: CONVST=0, acc and count cleared, no strobes. o_sample, o_avg and o_timeout hold their values.
- Timed-out conversions are excluded from the average; averaging continues with the next good sample.
- i_clr_timeout clears o_timeout. If a timeout occurs in the same cycle as the clear, set wins.

## Timing
- Reset values: o_CONVST=0, o_sample=0, o_sample_valid=0, o_avg=0, o_avg_valid=0, o_timeout=0. State=IDLE, all counters 0, s1=s2=p=1.
- Reset asserted mid-conversion: CONVST drops immediately (asynchronous). After release, the block restarts from IDLE.
- Start-up: i_enable sampled high at edge n puts the block in START and raises CONVST from edge n. CONVST falls at edge n+CONVST_WIDTH.
- Period: rising edges of CONVST occur exactly every CONV_PERIOD cycles while enabled, whether or not EOC arrived.
- EOC latency: EOC is low at edge k (captured into s1). s2 is low at k+1 and the edge is detected in the cycle following k+1. The block is in CAPTURE from edge k+2, so o_sample and o_sample_valid change at edge k+3. i_DATA is sampled at edge k+3.
- The ADC interface has no back-pressure; the strobes are not acknowledged.

## Test plan
- Reset then enable, with ADC model EOC falling 300 cycles after CONVST↑ and DATA=0x5A -> CONVST↑ at 0, 1000, 2000 with width 10. o_sample=0x5A with a valid pulse 3 cycles after each EOC↓.
- AVG_LOG2=2, samples 10, 20, 30, 41 -> o_avg=25 with o_avg_valid on the 4th sample_valid cycle; no o_avg_valid on samples 1-3.
- EOC never falls on conversion 2 -> o_timeout=1 at WAIT_EOC entry + 500. No sample_valid for that conversion. The next CONVST still lands on the 1000-cycle grid. i_clr_timeout then clears the flag.
- EOC glitch during START plus a second EOC↓ during HOLD -> both ignored; exactly one sample_valid per period.
- i_enable drops after 2 captured samples, then rises again -> CONVST low within 1 cycle. The restarted average needs 4 fresh samples. o_sample keeps its last value while disabled.
- i_RST pulsed low while CONVST is high -> CONVST=0 asynchronously and all outputs at their reset values.

Source files
------------

// File: rtl/adc8_conv_sequencer.sv
// adc8_conv_sequencer
//
// Conversion controller for one 8-bit rectifier ADC (battery voltage or current).
// Issues CONVST on a fixed period, waits for the synchronized falling edge of EOC,
// captures the data bus, publishes each sample with a one-cycle strobe and keeps a
// running block average over 2^AVG_LOG2 good samples. A conversion whose EOC never
// arrives sets a sticky timeout flag and is left out of the average.
//
// Parameters:
//   CONV_PERIOD   cycles between CONVST rising edges
//   CONVST_WIDTH  cycles CONVST is held high
//   EOC_TIMEOUT   max cycles spent waiting for EOC
//                 (CONVST_WIDTH + EOC_TIMEOUT + 2 < CONV_PERIOD)
//   AVG_LOG2      log2 of samples per average, 1..4
//
// Ports:
//   i_CLK           system clock (clk_100M)
//   i_RST           asynchronous active-low reset
//   i_enable        run conversions while high
//   i_clr_timeout   single-cycle pulse, clears o_timeout (a coincident timeout wins)
//   i_EOC           ADC end-of-conversion, asynchronous, falling edge = data valid
//   i_DATA          ADC data bus, stable while EOC is low
//   o_CONVST        conversion start, active high, registered
//   o_sample        last captured sample
//   o_sample_valid  one-cycle strobe when o_sample updates
//   o_avg           last block average (truncated)
//   o_avg_valid     one-cycle strobe when o_avg updates
//   o_timeout       sticky missed-EOC flag

module adc8_conv_sequencer #(
  parameter int unsigned CONV_PERIOD  = 1000,
  parameter int unsigned CONVST_WIDTH = 10,
  parameter int unsigned EOC_TIMEOUT  = 500,
  parameter int unsigned AVG_LOG2     = 2
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_enable,
  input  logic       i_clr_timeout,
  input  logic       i_EOC,
  input  logic [7:0] i_DATA,
  output logic       o_CONVST,
  output logic [7:0] o_sample,
  output logic       o_sample_valid,
  output logic [7:0] o_avg,
  output logic       o_avg_valid,
  output logic       o_timeout
);

  localparam int unsigned PCNT_W = $clog2(CONV_PERIOD);
  localparam int unsigned TCNT_W = $clog2(EOC_TIMEOUT + 1);
  localparam int unsigned ACC_W  = 8 + AVG_LOG2;

  localparam logic [PCNT_W-1:0] PERIOD_LAST = PCNT_W'(CONV_PERIOD - 1);
  localparam logic [PCNT_W-1:0] WIDTH_LAST  = PCNT_W'(CONVST_WIDTH - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST    = TCNT_W'(EOC_TIMEOUT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StStart   = 3'd1;
  localparam logic [2:0] StWaitEoc = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StHold    = 3'd4;

  // EOC synchronizer and edge detector; idle-high so reset never fakes an edge.
  logic eoc_s1_q, eoc_s2_q, eoc_p_q;
  logic eoc_fall;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      eoc_s1_q <= 1'b1;
      eoc_s2_q <= 1'b1;
      eoc_p_q  <= 1'b1;
    end else begin
      eoc_s1_q <= i_EOC;
      eoc_s2_q <= eoc_s1_q;
      eoc_p_q  <= eoc_s2_q;
    end
  end

  assign eoc_fall = eoc_p_q & ~eoc_s2_q;

  logic [2:0]          state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                convst_q, convst_d;
  logic [7:0]          sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic [7:0]          avg_q, avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic                timeout_q, timeout_d;
  logic [ACC_W-1:0]    sum;

  // Accumulator plus the sample being captured; cannot overflow ACC_W bits because
  // at most 2^AVG_LOG2 samples of 255 are ever summed.
  assign sum = acc_q + ACC_W'(i_DATA);

  always_comb begin
    state_d        = state_q;
    pcnt_d         = pcnt_q;
    tcnt_d         = tcnt_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    avg_d          = avg_q;
    avg_valid_d    = 1'b0;
    timeout_d      = timeout_q;

    // Clear first so that a timeout in the same cycle overrides it below.
    if (i_clr_timeout) begin
      timeout_d = 1'b0;
    end

    if (!i_enable) begin
      state_d = StIdle;
      pcnt_d  = '0;
      tcnt_d  = '0;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      // The period counter free-runs in every active state and only restarts when
      // a new CONVST begins, which keeps the CONVST grid independent of EOC.
      pcnt_d = pcnt_q + PCNT_W'(1);
      case (state_q)
        StIdle: begin
          state_d = StStart;
          pcnt_d  = '0;
        end
        StStart: begin
          if (pcnt_q == WIDTH_LAST) begin
            state_d = StWaitEoc;
            tcnt_d  = '0;
          end
        end
        StWaitEoc: begin
          if (eoc_fall) begin
            state_d = StCapture;
          end else if (tcnt_q == TMO_LAST) begin
            timeout_d = 1'b1;
            state_d   = StHold;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        StCapture: begin
          sample_d       = i_DATA;
          sample_valid_d = 1'b1;
          if (cnt_q == '1) begin
            avg_d       = sum[ACC_W-1:AVG_LOG2];
            avg_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + AVG_LOG2'(1);
          end
          state_d = StHold;
        end
        StHold: begin
          if (pcnt_q == PERIOD_LAST) begin
            state_d = StStart;
            pcnt_d  = '0;
          end
        end
        default: begin
          state_d = StIdle;
          pcnt_d  = '0;
        end
      endcase
    end
  end

  // Registered so the ADC pin never sees decode glitches.
  assign convst_d = (state_d == StStart);

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q        <= StIdle;
      pcnt_q         <= '0;
      tcnt_q         <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      convst_q       <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      avg_q          <= '0;
      avg_valid_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      tcnt_q         <= tcnt_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      convst_q       <= convst_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      avg_q          <= avg_d;
      avg_valid_q    <= avg_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign o_CONVST       = convst_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = sample_valid_q;
  assign o_avg          = avg_q;
  assign o_avg_valid    = avg_valid_q;
  assign o_timeout      = timeout_q;

endmodule
